// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt pending controller.
package irq_pkg;
  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;
endpackage

// File: rtl/irq_edge_det.sv
// Request capture: previous-sample register and edge/level capture select.
module irq_edge_det #(
  parameter int N    = 8,
  parameter int EDGE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] cap
);
  logic [N-1:0] prev_req;

  // prev_req resets low so a line already high at release counts as a rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_req <= '0;
    else        prev_req <= req_in;
  end

  assign cap = (EDGE != 0) ? (req_in & ~prev_req) : req_in;
endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending/overrun capture feeding an external priority encoder, with a
// one-index-at-a-time valid/ack offer and a settle cycle after each ack.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int EDGE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             en,
  input  logic             ack,
  input  logic             ovr_clr,
  input  logic             enc_valid,
  input  logic [IDX_W-1:0] enc_idx,
  output logic [N-1:0]     pend_vec,
  output logic             enc_en,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N-1:0]     overrun
);
  state_t       state, state_nxt;
  logic [N-1:0] pending;
  logic [N-1:0] cap;
  logic [N-1:0] clr;
  logic [N-1:0] ovr_set;
  logic         load_idx;

  irq_edge_det #(.N(N), .EDGE(EDGE)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_in),
    .cap    (cap)
  );

  // Only the index currently on offer is ever cleared, and only on its ack
  always_comb begin
    clr = '0;
    if (state == PRESENT && ack) clr[irq_idx] = 1'b1;
  end

  assign ovr_set = cap & pending & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= cap | (pending & ~clr);
      overrun <= ovr_clr ? ovr_set : (overrun | ovr_set);
    end
  end

  always_comb begin
    state_nxt = state;
    load_idx  = 1'b0;
    case (state)
      IDLE: begin
        if (en && enc_valid) begin
          load_idx  = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: if (ack) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_idx <= '0;
    end else begin
      state <= state_nxt;
      if (load_idx) irq_idx <= enc_idx;
    end
  end

  assign pend_vec  = pending & ~mask;
  assign enc_en    = en && (state == IDLE);
  assign irq_valid = (state == PRESENT);
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench: controller back-to-back with a behavioural 8x3 MSB-first encoder.
module tb_irq_pending_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in, mask;
  logic       en, ack, ovr_clr;
  logic       enc_valid;
  logic [2:0] enc_idx;
  logic [7:0] pend_vec, overrun;
  logic       enc_en, irq_valid;
  logic [2:0] irq_idx;

  logic [7:0] req1, mask1;
  logic       en1, ack1, ovr_clr1;
  logic       enc_valid1;
  logic [2:0] enc_idx1;
  logic [7:0] pend_vec1, overrun1;
  logic       enc_en1, irq_valid1;
  logic [2:0] irq_idx1;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_q1[$];

  always #5 clk = ~clk;

  irq_pending_ctrl #(.N(8), .IDX_W(3), .EDGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .en(en), .ack(ack),
    .ovr_clr(ovr_clr), .enc_valid(enc_valid), .enc_idx(enc_idx),
    .pend_vec(pend_vec), .enc_en(enc_en), .irq_valid(irq_valid),
    .irq_idx(irq_idx), .overrun(overrun)
  );

  irq_pending_ctrl #(.N(8), .IDX_W(3), .EDGE(0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req_in(req1), .mask(mask1), .en(en1), .ack(ack1),
    .ovr_clr(ovr_clr1), .enc_valid(enc_valid1), .enc_idx(enc_idx1),
    .pend_vec(pend_vec1), .enc_en(enc_en1), .irq_valid(irq_valid1),
    .irq_idx(irq_idx1), .overrun(overrun1)
  );

  // Encoder model: valid when enabled and any input set, y = highest set bit
  always_comb begin
    enc_valid = 1'b0;
    enc_idx   = 3'd0;
    if (enc_en)
      for (int k = 0; k < 8; k++)
        if (pend_vec[k]) begin
          enc_valid = 1'b1;
          enc_idx   = k[2:0];
        end
  end

  always_comb begin
    enc_valid1 = 1'b0;
    enc_idx1   = 3'd0;
    if (enc_en1)
      for (int m = 0; m < 8; m++)
        if (pend_vec1[m]) begin
          enc_valid1 = 1'b1;
          enc_idx1   = m[2:0];
        end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    req_in = v;
    tick();
    req_in = 8'h00;
  endtask

  // Wait for an offer, score it against the queue, ack it and check the gap cycle
  task automatic offer(input string tag, input int exp_n, input logic [7:0] req_at_ack);
    int n;
    logic [2:0] e;
    n = 0;
    while (!irq_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, n, exp_n);
    chk({tag, "_valid"}, irq_valid, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    chk({tag, "_idx"}, irq_idx, e);
    ack    = 1'b1;
    req_in = req_at_ack;
    tick();
    ack    = 1'b0;
    req_in = 8'h00;
    chk({tag, "_gap_valid"}, irq_valid, 1'b0);
    chk({tag, "_gap_en"}, enc_en, 1'b0);
  endtask

  initial begin
    int n;
    logic [2:0] e;
    rst_n = 1'b0; req_in = 8'h00; mask = 8'h00; en = 1'b1; ack = 1'b0; ovr_clr = 1'b0;
    req1 = 8'h00; mask1 = 8'h00; en1 = 1'b1; ack1 = 1'b0; ovr_clr1 = 1'b0;
    tick(); tick();
    chk("rst_valid", irq_valid, 1'b0);
    chk("rst_pend", pend_vec, 8'h00);
    chk("rst_ovr", overrun, 8'h00);
    chk("rst_idx", irq_idx, 3'd0);
    chk("rst_en", enc_en, 1'b1);
    rst_n = 1'b1;
    tick();

    // single request
    exp_q.push_back(3'd2);
    pulse(8'h04);
    chk("t1_pend", pend_vec, 8'h04);
    offer("t1", 1, 8'h00);
    chk("t1_clr", pend_vec, 8'h00);

    // priority drain
    exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd4);
    pulse(8'hB0);
    offer("t2a", 1, 8'h00);
    offer("t2b", 2, 8'h00);
    offer("t2c", 2, 8'h00);
    chk("t2_empty", pend_vec, 8'h00);

    // mask and enable
    mask = 8'h80;
    exp_q.push_back(3'd5); exp_q.push_back(3'd4);
    pulse(8'hB0);
    offer("t3a", 1, 8'h00);
    offer("t3b", 2, 8'h00);
    chk("t3_masked", pend_vec, 8'h00);
    mask = 8'h00;
    #1;
    chk("t3_unmask", pend_vec, 8'h80);
    exp_q.push_back(3'd7);
    offer("t3c", 2, 8'h00);
    en = 1'b0;
    pulse(8'h01);
    for (int i = 0; i < 4; i++) begin
      chk("t3_dis_valid", irq_valid, 1'b0);
      chk("t3_dis_en", enc_en, 1'b0);
      tick();
    end
    en = 1'b1;
    exp_q.push_back(3'd0);
    offer("t3d", 1, 8'h00);

    // collisions
    en = 1'b0;
    pulse(8'h20);
    tick();
    pulse(8'h20);
    chk("t4_ovr", overrun, 8'h20);
    en = 1'b1;
    exp_q.push_back(3'd5);
    offer("t4a", 1, 8'h20);
    chk("t4_keep", pend_vec, 8'h20);
    exp_q.push_back(3'd5);
    offer("t4b", 2, 8'h00);
    chk("t4_pend0", pend_vec, 8'h00);
    chk("t4_ovr_sticky", overrun, 8'h20);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 8'h00);

    // reset in the middle of an offer
    en = 1'b0;
    tick();
    pulse(8'h08);
    tick();
    pulse(8'h08);
    chk("t5_ovr", overrun, 8'h08);
    en = 1'b1;
    tick();
    chk("t5_valid", irq_valid, 1'b1);
    chk("t5_idx", irq_idx, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", irq_valid, 1'b0);
    chk("t5_rst_pend", pend_vec, 8'h00);
    chk("t5_rst_ovr", overrun, 8'h00);
    req_in = 8'h40;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(3'd6);
    offer("t5r", 2, 8'h40);
    chk("t5_after", pend_vec, 8'h00);

    // level-sensitive instance, request held high
    req1 = 8'h02;
    for (int r = 0; r < 3; r++) exp_q1.push_back(3'd1);
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!irq_valid1 && n < 12) begin
        tick();
        n++;
      end
      chk("t6_wait", n, 2);
      e = (exp_q1.size() != 0) ? exp_q1.pop_front() : 3'bxxx;
      chk("t6_idx", irq_idx1, e);
      ack1 = 1'b1;
      tick();
      ack1 = 1'b0;
      chk("t6_gap", irq_valid1, 1'b0);
    end
    chk("t6_ovr", overrun1, 8'h02);
    chk("t6_pend", pend_vec1, 8'h02);
    req1 = 8'h00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
